// File: rtl/contador_pkg.sv
// Shared types and constants for the hex counter slice: FSM state encoding,
// default counter width and the 7-segment glyphs used by the board top.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } estado_t;

    localparam int NBITS_CONTADOR_DEFAULT = 4;

    // Segment order {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] NUM_0   = 7'h3F;
    localparam logic [6:0] NUM_1   = 7'h06;
    localparam logic [6:0] NUM_2   = 7'h5B;
    localparam logic [6:0] NUM_3   = 7'h4F;
    localparam logic [6:0] NUM_4   = 7'h66;
    localparam logic [6:0] NUM_5   = 7'h6D;
    localparam logic [6:0] NUM_6   = 7'h7D;
    localparam logic [6:0] NUM_7   = 7'h07;
    localparam logic [6:0] NUM_8   = 7'h7F;
    localparam logic [6:0] NUM_9   = 7'h6F;
    localparam logic [6:0] LETRA_A = 7'h77;
    localparam logic [6:0] LETRA_B = 7'h7C;
    localparam logic [6:0] LETRA_C = 7'h39;
    localparam logic [6:0] LETRA_D = 7'h5E;
    localparam logic [6:0] LETRA_E = 7'h79;
    localparam logic [6:0] LETRA_F = 7'h71;

endpackage

// File: rtl/tick_divider.sv
// Step-rate divider: free-runs 0..TICK_DIV-1 while en, tick high on the last value.
// Latency: tick is combinational from the divider register; no backpressure.
module tick_divider #(
    parameter int TICK_DIV = 1
) (
    input  logic clk_2,
    input  logic reset,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int          W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] div_q;

    always_ff @(posedge clk_2) begin
        if (reset || clear) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= (div_q == LAST) ? '0 : div_q + W'(1);
        end
    end

    assign tick = (div_q == LAST);

endmodule

// File: rtl/contador_seq_ctrl.sv
// Run controller for the hex counter: start/stop/load pulses drive IDLE/RUN/HOLD/DONE sessions.
// Latency: one cycle from command edge to state/count; no backpressure, commands are edge pulses.
module contador_seq_ctrl
    import contador_pkg::*;
#(
    parameter int NBITS_CONTADOR = NBITS_CONTADOR_DEFAULT,
    parameter int TICK_DIV       = 1,
    parameter int RESET_CONTADOR = 0
) (
    input  logic                      clk_2,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      load,
    input  logic                      dir,
    input  logic                      wrap_en,
    input  logic [NBITS_CONTADOR-1:0] load_value,
    input  logic [NBITS_CONTADOR-1:0] limit,
    output logic [NBITS_CONTADOR-1:0] count,
    output logic [1:0]                state,
    output logic                      done,
    output logic                      wrap_pulse
);

    localparam int                N         = NBITS_CONTADOR;
    localparam logic [N-1:0]      RESET_VAL = N'(RESET_CONTADOR);
    localparam logic [N-1:0]      ONE       = N'(1);

    logic start_prev, stop_prev, load_prev;
    logic start_edge, stop_edge, load_edge;

    estado_t      state_q, state_nxt;
    logic [N-1:0] count_q, count_nxt;
    logic [N-1:0] base_q, base_nxt;
    logic         wrap_q, wrap_nxt;
    logic         div_en, div_clear, tick;

    // History flops track the inputs during reset too, so a level held through reset is not an edge.
    always_ff @(posedge clk_2) begin
        start_prev <= start;
        stop_prev  <= stop;
        load_prev  <= load;
    end

    assign start_edge = start & ~start_prev;
    assign stop_edge  = stop  & ~stop_prev;
    assign load_edge  = load  & ~load_prev;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk_2 (clk_2),
        .reset (reset),
        .en    (div_en),
        .clear (div_clear),
        .tick  (tick)
    );

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= RESET_VAL;
            base_q  <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            count_q <= count_nxt;
            base_q  <= base_nxt;
            wrap_q  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        count_nxt = count_q;
        base_nxt  = base_q;
        wrap_nxt  = 1'b0;
        div_en    = 1'b0;
        div_clear = 1'b0;

        if (load_edge) begin
            count_nxt = load_value;
            base_nxt  = load_value;
            div_clear = 1'b1;
            state_nxt = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // A coincident stop edge outranks start even though stop alone does nothing here.
                    if (start_edge && !stop_edge) begin
                        state_nxt = RUN;
                        div_clear = 1'b1;
                    end
                end
                RUN: begin
                    if (stop_edge) begin
                        state_nxt = HOLD;
                    end else begin
                        div_en = 1'b1;
                        if (tick) begin
                            if (count_q == limit) begin
                                if (wrap_en) begin
                                    count_nxt = base_q;
                                    wrap_nxt  = 1'b1;
                                end else begin
                                    state_nxt = DONE;
                                end
                            end else begin
                                count_nxt = dir ? count_q - ONE : count_q + ONE;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (stop_edge) begin
                        state_nxt = IDLE;
                    end else if (start_edge) begin
                        state_nxt = RUN;
                    end
                end
                DONE: begin
                    if (stop_edge) begin
                        state_nxt = IDLE;
                    end else if (start_edge) begin
                        count_nxt = base_q;
                        div_clear = 1'b1;
                        state_nxt = RUN;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign count      = count_q;
    assign state      = state_q;
    assign done       = (state_q == DONE);
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_contador_seq_ctrl.sv
// Scoreboard bench: two instances (TICK_DIV=1 and TICK_DIV=4) share stimulus;
// each expected observation is queued with its target cycle and checked by a monitor.
module tb_contador_seq_ctrl;
    import contador_pkg::*;

    logic       clk_2;
    logic       reset, start, stop, load, dir, wrap_en;
    logic [3:0] load_value, limit;
    logic [3:0] count1, count4;
    logic [1:0] state1, state4;
    logic       done1, done4, wrap1, wrap4;

    contador_seq_ctrl #(.NBITS_CONTADOR(4), .TICK_DIV(1), .RESET_CONTADOR(0)) dut1 (
        .clk_2(clk_2), .reset(reset), .start(start), .stop(stop), .load(load),
        .dir(dir), .wrap_en(wrap_en), .load_value(load_value), .limit(limit),
        .count(count1), .state(state1), .done(done1), .wrap_pulse(wrap1)
    );

    contador_seq_ctrl #(.NBITS_CONTADOR(4), .TICK_DIV(4), .RESET_CONTADOR(0)) dut4 (
        .clk_2(clk_2), .reset(reset), .start(start), .stop(stop), .load(load),
        .dir(dir), .wrap_en(wrap_en), .load_value(load_value), .limit(limit),
        .count(count4), .state(state4), .done(done4), .wrap_pulse(wrap4)
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    typedef struct {
        int         cyc;
        int         sel;
        string      name;
        logic [3:0] cnt;
        logic [1:0] st;
        logic       w;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [3:0] t3_cnt [7] = '{4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1};
    logic       t3_w   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] t4_cnt [6] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};

    always @(posedge clk_2) cyc <= cyc + 1;

    // Queue an expectation for the sample taken after the next rising edge.
    task automatic ex(input int sel, input string name, input logic [3:0] c,
                      input logic [1:0] s, input logic w);
        exp_t e;
        e.cyc  = cyc + 1;
        e.sel  = sel;
        e.name = name;
        e.cnt  = c;
        e.st   = s;
        e.w    = w;
        sb.push_back(e);
    endtask

    task automatic drive(input logic ld, input logic st, input logic sp);
        @(negedge clk_2);
        load  = ld;
        start = st;
        stop  = sp;
    endtask

    always @(negedge clk_2) begin
        exp_t       e;
        logic [3:0] ac;
        logic [1:0] as;
        logic       ad, aw, ed;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e  = sb.pop_front();
            ac = (e.sel == 0) ? count1 : count4;
            as = (e.sel == 0) ? state1 : state4;
            ad = (e.sel == 0) ? done1  : done4;
            aw = (e.sel == 0) ? wrap1  : wrap4;
            ed = (e.st == DONE);
            n_checks++;
            if (ac !== e.cnt || as !== e.st || ad !== ed || aw !== e.w) begin
                n_fail++;
                $display("FAIL %s (dut%0d, cycle %0d): got count=%h state=%0d done=%b wrap=%b, want count=%h state=%0d done=%b wrap=%b",
                         e.name, (e.sel == 0) ? 1 : 4, cyc, ac, as, ad, aw, e.cnt, e.st, ed, e.w);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached with %0d expectations pending", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b1; stop = 1'b0; load = 1'b0;
        dir = 1'b0; wrap_en = 1'b0; load_value = 4'd0; limit = 4'd0;

        // Test 1: start held high across reset release must not start a run.
        ex(0, "reset_1", 4'd0, IDLE, 1'b0);
        ex(1, "reset_4", 4'd0, IDLE, 1'b0);
        @(negedge clk_2);
        ex(0, "reset_1b", 4'd0, IDLE, 1'b0);
        @(negedge clk_2);
        reset = 1'b0;
        ex(0, "held_start_1", 4'd0, IDLE, 1'b0);
        ex(1, "held_start_4", 4'd0, IDLE, 1'b0);
        @(negedge clk_2);
        ex(0, "held_start_1b", 4'd0, IDLE, 1'b0);

        // Test 2: count up 3..6 then stop at the limit.
        drive(1, 0, 0);
        load_value = 4'd3; limit = 4'd6; dir = 1'b0; wrap_en = 1'b0;
        ex(0, "t2_load", 4'd3, IDLE, 1'b0);
        drive(0, 1, 0);
        ex(0, "t2_start", 4'd3, RUN, 1'b0);
        for (int v = 4; v <= 6; v++) begin
            drive(0, 0, 0);
            ex(0, "t2_run", 4'(v), RUN, 1'b0);
        end
        drive(0, 0, 0);
        ex(0, "t2_done", 4'd6, DONE, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0);
            ex(0, "t2_done_hold", 4'd6, DONE, 1'b0);
        end

        // Test 3: count down with reload at the limit.
        drive(1, 0, 0);
        load_value = 4'd2; limit = 4'd0; dir = 1'b1; wrap_en = 1'b1;
        ex(0, "t3_load", 4'd2, IDLE, 1'b0);
        drive(0, 1, 0);
        ex(0, "t3_start", 4'd2, RUN, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0);
            ex(0, "t3_wrap_seq", t3_cnt[i], RUN, t3_w[i]);
        end

        // Test 4: TICK_DIV=4, hold freezes the divider.
        drive(1, 0, 0);
        load_value = 4'd0; limit = 4'hF; dir = 1'b0; wrap_en = 1'b0;
        ex(1, "t4_load", 4'd0, IDLE, 1'b0);
        drive(0, 1, 0);
        ex(1, "t4_start", 4'd0, RUN, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0);
            ex(1, "t4_div", t4_cnt[i], RUN, 1'b0);
        end
        drive(0, 0, 1);
        ex(1, "t4_stop", 4'd1, HOLD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0);
            ex(1, "t4_hold", 4'd1, HOLD, 1'b0);
        end
        drive(0, 1, 0);
        ex(1, "t4_resume", 4'd1, RUN, 1'b0);
        drive(0, 0, 0);
        ex(1, "t4_resume_wait", 4'd1, RUN, 1'b0);
        drive(0, 0, 0);
        ex(1, "t4_step", 4'd2, RUN, 1'b0);
        drive(0, 0, 0);
        ex(1, "t4_after_step", 4'd2, RUN, 1'b0);

        // Test 5: coincident load/stop/start in RUN; load wins and sets base.
        drive(1, 0, 0);
        load_value = 4'd0; limit = 4'hF; dir = 1'b0; wrap_en = 1'b1;
        ex(0, "t5_load0", 4'd0, IDLE, 1'b0);
        drive(0, 1, 0);
        ex(0, "t5_start", 4'd0, RUN, 1'b0);
        drive(0, 0, 0);
        ex(0, "t5_run", 4'd1, RUN, 1'b0);
        drive(1, 1, 1);
        load_value = 4'd9;
        ex(0, "t5_priority", 4'd9, IDLE, 1'b0);
        drive(0, 0, 0);
        limit = 4'd9;
        ex(0, "t5_idle", 4'd9, IDLE, 1'b0);
        drive(0, 1, 0);
        ex(0, "t5_restart", 4'd9, RUN, 1'b0);
        drive(0, 0, 0);
        ex(0, "t5_base_reload", 4'd9, RUN, 1'b1);
        drive(0, 0, 0);
        ex(0, "t5_base_reload2", 4'd9, RUN, 1'b1);

        // Test 6: modulo-16 wrap up to the limit, then restart from DONE.
        drive(1, 0, 0);
        load_value = 4'hE; limit = 4'd1; dir = 1'b0; wrap_en = 1'b0;
        ex(0, "t6_load", 4'hE, IDLE, 1'b0);
        drive(0, 1, 0);
        ex(0, "t6_start", 4'hE, RUN, 1'b0);
        drive(0, 0, 0);
        ex(0, "t6_F", 4'hF, RUN, 1'b0);
        drive(0, 0, 0);
        ex(0, "t6_0", 4'h0, RUN, 1'b0);
        drive(0, 0, 0);
        ex(0, "t6_1", 4'h1, RUN, 1'b0);
        drive(0, 0, 0);
        ex(0, "t6_done", 4'h1, DONE, 1'b0);
        drive(0, 0, 0);
        ex(0, "t6_done_hold", 4'h1, DONE, 1'b0);
        drive(0, 1, 0);
        ex(0, "t6_reload_base", 4'hE, RUN, 1'b0);
        drive(0, 0, 0);
        ex(0, "t6_after_reload", 4'hF, RUN, 1'b0);

        drive(0, 0, 0);
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk_2);
        @(negedge clk_2);
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations never checked, required 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_seq_ctrl.md
Name: contador_seq_ctrl

Overview:
- Run controller for the 4-bit synchronous hex counter that drives LED/SEG in the top-level board wrapper.
- Turns start/stop/load command pulses into counting sessions: programmable start value, limit, direction, step rate, and stop-or-reload behaviour at the limit.
- Owns the count register and exposes count, state and status to the top. The top keeps the 7-segment decode.

Parameters:
- NBITS_CONTADOR, 4: counter width. Arithmetic is modulo 2**NBITS_CONTADOR.
- TICK_DIV, 1: counter steps once every TICK_DIV clk_2 cycles while running. Must be ≥1.
- RESET_CONTADOR, 0: reset value of count and base.

Ports:
- clk_2  in  1  single system clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  command, rising-edge detected internally.
- stop  in  1  command, rising-edge detected internally.
- load  in  1  command, rising-edge detected internally.
- dir  in  1  level: 0 counts up, 1 counts down; sampled on every tick.
- wrap_en  in  1  level: 1 reloads base at the limit, 0 stops at the limit.
- load_value  in  NBITS_CONTADOR  value captured on a load edge.
- limit  in  NBITS_CONTADOR  terminal value.
- count  out  NBITS_CONTADOR  current count (registered).
- state  out  2  IDLE=0, RUN=1, HOLD=2, DONE=3 (registered).
- done  out  1  high exactly while state==DONE.
- wrap_pulse  out  1  one-cycle pulse on each reload at the limit.

Behaviour:
- Reset: state IDLE, count=base=RESET_CONTADOR, divider=0, done=0, wrap_pulse=0.
- While reset is high, each edge-detector history flop loads the current input, so an input held high through reset does not create an edge.
- Edge detection: x_edge = x & ~x_prev.
- Priority when edges coincide: load > stop > start, in every state.
- Tick generation:
  - The divider counts 0..TICK_DIV-1 only in RUN.
  - tick is asserted in the cycle where divider==TICK_DIV-1.
  - With TICK_DIV=1, tick is asserted every RUN cycle.
- load_edge, any state: count<=load_value, base<=load_value, divider<=0, state<=IDLE.
- IDLE:
  - start_edge -> RUN, divider<=0.
  - stop_edge is ignored.
- RUN, on tick:
  - count≠limit: count<=count±1 mod 2**N, per dir.
  - count==limit, wrap_en=0: state<=DONE, count unchanged.
  - count==limit, wrap_en=1: count<=base and wrap_pulse=1 for one cycle; stay in RUN.
  - The comparison uses the pre-step count, so entering RUN with count==limit terminates or reloads on the first tick without stepping.
- RUN, stop_edge -> HOLD. The divider freezes, and a tick in the same cycle is suppressed (no step).
- HOLD:
  - start_edge -> RUN; the divider resumes from its frozen value.
  - stop_edge -> IDLE; count is held.
- DONE:
  - count is held.
  - start_edge -> count<=base, divider<=0, RUN.
  - stop_edge -> IDLE.
- Latency: a start edge sampled at edge N gives state=RUN after edge N. With TICK_DIV=1, the first count change is visible after edge N+1.
- Reset asserted mid-run overrides everything in the same edge.

Decomposition:
- contador_pkg holds:
  - estado_t enum (IDLE, RUN, HOLD, DONE; 2 bits);
  - NBITS_CONTADOR default;
  - the shared 7-segment constants NUM_0..LETRA_F, so the top and this block use one definition.
- Sub-module tick_divider (inputs clk_2, reset, en, clear; output tick; parameter TICK_DIV) holds the divider.
- Edge detectors and the FSM stay inline.

Test Plan:
1. Hold start=1 with reset high for 2 cycles, release with start still high -> state=IDLE, count=0, no RUN entry.
2. TICK_DIV=1: load_value=3 with a load pulse, limit=6, dir=0, wrap_en=0, start pulse -> count 3,4,5,6 on consecutive cycles; next cycle state=DONE, done=1, count stays 6 for 10 cycles.
3. dir=1, load 2, limit=0, wrap_en=1, start -> count 2,1,0,2,1,0…; wrap_pulse high exactly one cycle at each 0->2 reload.
4. TICK_DIV=4, load 0, limit=F: stop edge 2 cycles after a step -> HOLD, count frozen 10 cycles; start -> next step exactly 2 cycles later.
5. In RUN, assert load, stop and start edges in the same cycle with load_value=9 -> count=9, state=IDLE, base=9.
6. TICK_DIV=1: load E, limit=1, dir=0, wrap_en=0 -> count E,F,0,1, then DONE (mod-16 wrap). Start in DONE -> count reloads to E, state RUN.
